// File: rtl/vga_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen_if
// Brief    : Pattern select input plus raster timing and pixel outputs.
// Revision : 1.0
// ============================================================================
interface vga_pattern_gen_if #(
   parameter int COLOR_W = 1
);
   logic [2:0]           mode;
   logic [3*COLOR_W-1:0] disp_RGB;
   logic                 hsync;
   logic                 vsync;
   logic                 data_en;
   logic [9:0]           pixel_x;
   logic [9:0]           pixel_y;
   logic                 frame_start;

   modport master (
      input  mode,
      output disp_RGB, hsync, vsync, data_en, pixel_x, pixel_y, frame_start
   );

   modport slave (
      output mode,
      input  disp_RGB, hsync, vsync, data_en, pixel_x, pixel_y, frame_start
   );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen
// Brief    : Parametrised VGA timing and eight-pattern test generator.
// Revision : 1.0
// ============================================================================
module vga_pattern_gen #(
   parameter int CLK_DIV     = 2,
   parameter int COLOR_W     = 1,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int H_ACTIVE    = 640,
   parameter int H_FRONT     = 16,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int V_ACTIVE    = 480,
   parameter int V_FRONT     = 10,
   parameter bit SYNC_POL    = 1'b0,
   parameter int CHECK_LOG2  = 5,
   parameter int SCROLL_LOG2 = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   vga_pattern_gen_if.master vga
);
   localparam int H_TOT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int HSW   = $clog2(H_ACTIVE / 8 + 1);
   localparam int VSW   = $clog2(V_ACTIVE / 8 + 1);
   localparam int FCW   = SCROLL_LOG2 + 3;

   localparam logic [HW-1:0]  H_LAST     = HW'(H_TOT - 1);
   localparam logic [HW-1:0]  H_SYNC_END = HW'(H_SYNC);
   localparam logic [HW-1:0]  H_ACT_BEG  = HW'(H_SYNC + H_BACK);
   localparam logic [HW-1:0]  H_ACT_END  = HW'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [VW-1:0]  V_LAST     = VW'(V_TOT - 1);
   localparam logic [VW-1:0]  V_SYNC_END = VW'(V_SYNC);
   localparam logic [VW-1:0]  V_ACT_BEG  = VW'(V_SYNC + V_BACK);
   localparam logic [VW-1:0]  V_ACT_END  = VW'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [HSW-1:0] HSUB_LAST  = HSW'(H_ACTIVE / 8 - 1);
   localparam logic [VSW-1:0] VSUB_LAST  = VSW'(V_ACTIVE / 8 - 1);

   logic w_pix_en;

   generate
      if (CLK_DIV > 1) begin : g_div
         localparam int DW = $clog2(CLK_DIV);
         localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
         logic [DW-1:0] r_div_cnt;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)                  r_div_cnt <= '0;
            else if (r_div_cnt == DIV_LAST) r_div_cnt <= '0;
            else                           r_div_cnt <= r_div_cnt + 1'b1;
         end

         assign w_pix_en = (r_div_cnt == DIV_LAST);
      end else begin : g_no_div
         assign w_pix_en = 1'b1;
      end
   endgenerate

   logic [HW-1:0]  r_h;
   logic [VW-1:0]  r_v;
   logic [HSW-1:0] r_hsub;
   logic [VSW-1:0] r_vsub;
   logic [2:0]     r_hbar, r_vbar;
   logic [2:0]     r_mode_q;
   logic [FCW-1:0] r_frame_cnt;

   logic w_h_last, w_v_last, w_frame_wrap, w_h_act, w_v_act, w_active;
   logic [HW-1:0] w_x;
   logic [VW-1:0] w_y;

   assign w_h_last     = (r_h == H_LAST);
   assign w_v_last     = (r_v == V_LAST);
   assign w_frame_wrap = w_pix_en & w_h_last & w_v_last;
   assign w_h_act      = (r_h >= H_ACT_BEG) && (r_h < H_ACT_END);
   assign w_v_act      = (r_v >= V_ACT_BEG) && (r_v < V_ACT_END);
   assign w_active     = w_h_act & w_v_act;
   assign w_x          = r_h - H_ACT_BEG;
   assign w_y          = r_v - V_ACT_BEG;

   // Bar indices track the current counters; sub-counters replace x/(H_ACTIVE/8).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_h         <= '0;
         r_v         <= '0;
         r_hsub      <= '0;
         r_vsub      <= '0;
         r_hbar      <= '0;
         r_vbar      <= '0;
         r_mode_q    <= '0;
         r_frame_cnt <= '0;
      end else if (w_pix_en) begin
         r_h <= w_h_last ? '0 : r_h + 1'b1;

         if (w_h_act) begin
            if (r_hsub == HSUB_LAST) begin
               r_hsub <= '0;
               r_hbar <= r_hbar + 1'b1;
            end else begin
               r_hsub <= r_hsub + 1'b1;
            end
         end else begin
            r_hsub <= '0;
            r_hbar <= '0;
         end

         if (w_h_last) begin
            r_v <= w_v_last ? '0 : r_v + 1'b1;
            if (w_v_act) begin
               if (r_vsub == VSUB_LAST) begin
                  r_vsub <= '0;
                  r_vbar <= r_vbar + 1'b1;
               end else begin
                  r_vsub <= r_vsub + 1'b1;
               end
            end else begin
               r_vsub <= '0;
               r_vbar <= '0;
            end
         end

         if (w_frame_wrap) begin
            r_mode_q    <= vga.mode;
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   logic [2:0]           w_scroll, w_sbar, w_code;
   logic [3*COLOR_W-1:0] w_rgb;

   assign w_scroll = r_frame_cnt[SCROLL_LOG2 +: 3];
   assign w_sbar   = r_hbar + w_scroll;

   // Colour code is 7-bar, i.e. the bitwise inverse of the 3-bit bar index.
   always_comb begin
      w_code = 3'b000;
      case (r_mode_q)
         3'd0:    w_code = ~r_vbar;
         3'd1:    w_code = ~r_hbar;
         3'd2:    w_code = r_vbar ^ r_hbar;
         3'd3:    w_code = ~(r_vbar ^ r_hbar);
         3'd4:    w_code = {3{w_x[CHECK_LOG2] ^ w_y[CHECK_LOG2]}};
         3'd5:    w_code = ~w_sbar;
         3'd6:    w_code = 3'b111;
         default: w_code = 3'b000;
      endcase
   end

   assign w_rgb = {{COLOR_W{w_code[2]}}, {COLOR_W{w_code[1]}}, {COLOR_W{w_code[0]}}};

   logic [3*COLOR_W-1:0] r_rgb;
   logic                 r_hsync, r_vsync, r_de, r_frame_start;
   logic [9:0]           r_px, r_py;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rgb         <= '0;
         r_hsync       <= ~SYNC_POL;
         r_vsync       <= ~SYNC_POL;
         r_de          <= 1'b0;
         r_px          <= '0;
         r_py          <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_frame_wrap;
         if (w_pix_en) begin
            r_hsync <= (r_h < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            r_vsync <= (r_v < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            r_de    <= w_active;
            r_px    <= w_active ? 10'(w_x) : 10'd0;
            r_py    <= w_active ? 10'(w_y) : 10'd0;
            r_rgb   <= w_active ? w_rgb : '0;
         end
      end
   end

   assign vga.disp_RGB    = r_rgb;
   assign vga.hsync       = r_hsync;
   assign vga.vsync       = r_vsync;
   assign vga.data_en     = r_de;
   assign vga.pixel_x     = r_px;
   assign vga.pixel_y     = r_py;
   assign vga.frame_start = r_frame_start;
endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pattern_gen
// Brief    : Self-checking bench: arithmetic raster model, point table, corners.
// Revision : 1.0
// ============================================================================
module tb_vga_pattern_gen;
   localparam int CLK_DIV = 2, COLOR_W = 2;
   localparam int H_SYNC = 8, H_BACK = 8, H_ACTIVE = 32, H_FRONT = 8;
   localparam int V_SYNC = 2, V_BACK = 2, V_ACTIVE = 16, V_FRONT = 2;
   localparam bit SYNC_POL = 1'b0;
   localparam int CHECK_LOG2 = 2, SCROLL_LOG2 = 1;
   localparam int H_TOT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int FRAME = H_TOT * V_TOT;
   localparam int FRAME_CLK = FRAME * CLK_DIV;
   localparam int RW = 3 * COLOR_W;
   localparam int NV = 17;

   logic clk = 1'b0;
   logic rst_n;

   vga_pattern_gen_if #(.COLOR_W(COLOR_W)) vif ();

   vga_pattern_gen #(
      .CLK_DIV(CLK_DIV), .COLOR_W(COLOR_W),
      .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
      .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT),
      .SYNC_POL(SYNC_POL), .CHECK_LOG2(CHECK_LOG2), .SCROLL_LOG2(SCROLL_LOG2)
   ) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .vga     (vif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] mode;
      int         frame;   // -1: any frame
      int         x;
      int         y;
      logic [2:0] code;
   } vec_t;

   vec_t vecs [0:NV-1];

   int unsigned n_vec = 0, n_err = 0;

   int         clk_cnt, pix_cnt, frame_num;
   logic [2:0] mq;
   logic [RW-1:0] e_rgb;
   logic       e_hs, e_vs, e_de, e_fs;
   int         e_x, e_y;
   bit         m_pix;
   logic [2:0] m_mode;
   int         m_frame;

   function automatic logic [RW-1:0] expand(input logic [2:0] c);
      return {{COLOR_W{c[2]}}, {COLOR_W{c[1]}}, {COLOR_W{c[0]}}};
   endfunction

   function automatic logic [2:0] exp_code(input logic [2:0] md, input int x, input int y, input int fr);
      int hb, vb, sc;
      hb = x / (H_ACTIVE / 8);
      vb = y / (V_ACTIVE / 8);
      sc = (fr >> SCROLL_LOG2) % 8;
      case (md)
         3'd0:    return 3'(7 - vb);
         3'd1:    return 3'(7 - hb);
         3'd2:    return 3'(7 - vb) ^ 3'(7 - hb);
         3'd3:    return ~(3'(7 - vb) ^ 3'(7 - hb));
         3'd4:    return ((((x >> CHECK_LOG2) ^ (y >> CHECK_LOG2)) & 1) != 0) ? 3'd7 : 3'd0;
         3'd5:    return 3'(7 - ((hb + sc) % 8));
         3'd6:    return 3'd7;
         default: return 3'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out waiting, got no event expected one at %0t", name, $time);
   endtask

   task automatic model_reset();
      clk_cnt = 0; pix_cnt = 0; frame_num = 0; mq = 3'd0;
      e_rgb = '0; e_hs = ~SYNC_POL; e_vs = ~SYNC_POL; e_de = 1'b0; e_fs = 1'b0;
      e_x = 0; e_y = 0; m_pix = 1'b0;
   endtask

   task automatic check_outputs(input string name);
      check(name,
            64'({vif.disp_RGB, vif.hsync, vif.vsync, vif.data_en, vif.pixel_x, vif.pixel_y, vif.frame_start}),
            64'({e_rgb, e_hs, e_vs, e_de, 10'(e_x), 10'(e_y), e_fs}));
   endtask

   // One clock: advance the model from its pixel index, then compare everything.
   task automatic tick();
      int q, h, v;
      @(posedge clk);
      m_pix = 1'b0;
      if (!rst_n) begin
         model_reset();
      end else begin
         clk_cnt++;
         e_fs = 1'b0;
         if (clk_cnt % CLK_DIV == 0) begin
            m_pix   = 1'b1;
            q       = pix_cnt % FRAME;
            h       = q % H_TOT;
            v       = q / H_TOT;
            m_mode  = mq;
            m_frame = frame_num;
            e_hs    = (h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
            e_vs    = (v < V_SYNC) ? SYNC_POL : ~SYNC_POL;
            e_de    = (h >= H_SYNC + H_BACK) && (h < H_SYNC + H_BACK + H_ACTIVE) &&
                      (v >= V_SYNC + V_BACK) && (v < V_SYNC + V_BACK + V_ACTIVE);
            e_x     = e_de ? h - (H_SYNC + H_BACK) : 0;
            e_y     = e_de ? v - (V_SYNC + V_BACK) : 0;
            e_rgb   = e_de ? expand(exp_code(mq, e_x, e_y, frame_num)) : '0;
            if (q == FRAME - 1) begin
               e_fs = 1'b1;
               mq   = vif.mode;
               frame_num++;
            end
            pix_cnt++;
         end
      end
      #1;
      check_outputs("raster");
   endtask

   task automatic wait_pixel(input logic [2:0] md, input int x, input int y, input int fr, output bit hit);
      int budget;
      budget = 5 * FRAME_CLK;
      hit = 1'b0;
      while (!hit && budget > 0) begin
         tick();
         budget--;
         if (m_pix && e_de && m_mode == md && e_x == x && e_y == y && (fr < 0 || m_frame == fr))
            hit = 1'b1;
      end
   endtask

   task automatic check_point(input vec_t t);
      bit hit;
      vif.mode = t.mode;
      wait_pixel(t.mode, t.x, t.y, t.frame, hit);
      if (hit)
         check($sformatf("mode%0d rgb at (%0d,%0d)", t.mode, t.x, t.y),
               64'(vif.disp_RGB), 64'(expand(t.code)));
      else
         timeout($sformatf("mode%0d pixel (%0d,%0d)", t.mode, t.x, t.y));
   endtask

   initial begin
      int  bad, hs_cnt, vs_cnt, de_cnt, fs_cnt, cnt, budget;
      bit  hit, seen;

      vecs[0]  = '{3'd1, -1,  0,  0, 3'b111};
      vecs[1]  = '{3'd1, -1,  4,  0, 3'b110};
      vecs[2]  = '{3'd1, -1, 31,  0, 3'b000};
      vecs[3]  = '{3'd0, -1,  5,  0, 3'b111};
      vecs[4]  = '{3'd0, -1, 31,  3, 3'b110};
      vecs[5]  = '{3'd0, -1,  0, 15, 3'b000};
      vecs[6]  = '{3'd2, -1,  0,  2, 3'b001};
      vecs[7]  = '{3'd2, -1,  4,  2, 3'b000};
      vecs[8]  = '{3'd3, -1,  4,  2, 3'b111};
      vecs[9]  = '{3'd4, -1,  0,  0, 3'b000};
      vecs[10] = '{3'd4, -1,  4,  0, 3'b111};
      vecs[11] = '{3'd4, -1,  0,  4, 3'b111};
      vecs[12] = '{3'd4, -1,  4,  4, 3'b000};
      vecs[13] = '{3'd6, -1, 10,  7, 3'b111};
      vecs[14] = '{3'd7, -1, 10,  7, 3'b000};
      vecs[15] = '{3'd5,  8,  4,  0, 3'b010};
      vecs[16] = '{3'd5, 10,  0,  1, 3'b010};

      vif.mode = 3'd0;
      rst_n    = 1'b1;
      #1 rst_n = 1'b0;
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) check_point(vecs[i]);

      // Mode 6 -> 7 switched mid-frame must leave the current frame white.
      vif.mode = 3'd6;
      wait_pixel(3'd6, 0, 8, -1, hit);
      if (!hit) timeout("mid-frame anchor");
      vif.mode = 3'd7;
      bad = 0; fs_cnt = 0; budget = 2 * FRAME_CLK;
      while (!e_fs && budget > 0) begin
         tick();
         budget--;
         if (m_pix && e_de && vif.disp_RGB != {RW{1'b1}}) bad++;
      end
      check("white remainder after switch", 64'(bad), 64'd0);

      bad = 0; hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
      for (int i = 0; i < FRAME_CLK; i++) begin
         tick();
         if (vif.hsync == SYNC_POL) hs_cnt++;
         if (vif.vsync == SYNC_POL) vs_cnt++;
         if (vif.data_en) begin
            de_cnt++;
            if (vif.disp_RGB != '0) bad++;
         end
         if (vif.frame_start) fs_cnt++;
      end
      check("black frame non-zero pixels", 64'(bad), 64'd0);
      check("hsync active clocks/frame", 64'(hs_cnt), 64'(H_SYNC * V_TOT * CLK_DIV));
      check("vsync active clocks/frame", 64'(vs_cnt), 64'(V_SYNC * H_TOT * CLK_DIV));
      check("data_en clocks/frame", 64'(de_cnt), 64'(H_ACTIVE * V_ACTIVE * CLK_DIV));
      check("frame_start pulses/frame", 64'(fs_cnt), 64'd1);

      for (int i = 0; i < 4 * FRAME_CLK; i++) begin
         if ($urandom_range(0, 299) == 0) vif.mode = 3'($urandom_range(0, 7));
         tick();
      end

      // Asynchronous reset in the middle of an active line.
      vif.mode = 3'd1;
      wait_pixel(3'd1, 10, 3, -1, hit);
      if (!hit) timeout("reset anchor");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async reset");
      tick();
      tick();
      rst_n = 1'b1;
      cnt = 0; seen = 1'b0; budget = 2 * FRAME_CLK;
      while (!seen && budget > 0) begin
         tick();
         budget--;
         if (m_pix) cnt++;
         if (vif.frame_start) seen = 1'b1;
      end
      check("pix_en count to first frame_start", 64'(cnt), 64'(FRAME));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
